// File: rtl/ram_fifo_ctrl.sv
// Single-clock FIFO sequencer driving an external async-read dual-port RAM.
// Define RAM_FIFO_PEAK_EN to add the occupancy high-water mark port "peak".
module ram_fifo_ctrl #(
  parameter int DEPTH        = 16,
  parameter int WIDTH        = 8,
  parameter int AFULL_THRESH = DEPTH - 2,
  localparam int AW          = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             ram_wenc,
  output logic [AW-1:0]    ram_waddr,
  output logic [WIDTH-1:0] ram_wdata,
  output logic             ram_renc,
  output logic [AW-1:0]    ram_raddr,
  input  logic [WIDTH-1:0] ram_rdata,
  output logic [AW:0]      count,
  output logic             almost_full
`ifdef RAM_FIFO_PEAK_EN
  ,
  output logic [AW:0]      peak
`endif
);

  localparam logic [AW:0] AF_LVL = (AW+1)'(AFULL_THRESH);
  localparam logic [AW:0] ONE    = (AW+1)'(1);

  logic [AW:0] wptr;
  logic [AW:0] rptr;
  logic [AW:0] count_nxt;
  logic        full;
  logic        empty;
  logic        push;
  logic        pop;

  // Wrap bit distinguishes full from empty when the addresses match.
  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty = (wptr == rptr);

  assign in_ready  = !full && !flush;
  assign out_valid = !empty && !flush;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign ram_wenc  = push;
  assign ram_waddr = wptr[AW-1:0];
  assign ram_wdata = in_data;
  assign ram_renc  = out_valid;
  assign ram_raddr = rptr[AW-1:0];
  assign out_data  = ram_rdata;

  assign almost_full = (count >= AF_LVL);

  always_comb begin
    count_nxt = count;
    unique case ({push, pop})
      2'b10:   count_nxt = count + ONE;
      2'b01:   count_nxt = count - ONE;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + ONE;
      if (pop)  rptr <= rptr + ONE;
      count <= count_nxt;
    end
  end

`ifdef RAM_FIFO_PEAK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      peak <= '0;
    end else if (flush) begin
      peak <= '0;
    end else if (count_nxt > peak) begin
      peak <= count_nxt;
    end
  end
`endif

endmodule
